// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - request/response bundle for one data-memory requester port
interface dmem_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              valid;
    logic              ready;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (
        output valid, we, addr, wdata,
        input  ready, rvalid, rdata, err
    );

    modport slave (
        input  valid, we, addr, wdata,
        output ready, rvalid, rdata, err
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/DMA arbiter and sequencer for the 16-bit data memory
// Optional feature: DMEM_ARB_RR_EN selects round-robin contention instead of CPU priority with MAX_WAIT.
module dmem_arbiter #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int MEM_BYTES = 16,
    parameter int MAX_WAIT  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    dmem_arbiter_if.slave     io_cpu,
    dmem_arbiter_if.slave     io_dma,
    output logic              o_mem_write_enable,
    output logic              o_mem_read_enable,
    output logic [ADDR_W-1:0] o_mem_address,
    output logic [DATA_W-1:0] o_mem_data_in,
    input  logic [DATA_W-1:0] i_mem_data_out
);
    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    localparam logic [ADDR_W-1:0] LAST_OK = ADDR_W'(MEM_BYTES - 4);

    state_t            r_state;
    logic              r_mem_we;
    logic              r_mem_re;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_s1_dma;
    logic              r_s1_oor;
    logic              r_cpu_rvalid, r_dma_rvalid;
    logic [DATA_W-1:0] r_cpu_rdata, r_dma_rdata;
    logic              r_cpu_err, r_dma_err;

    logic              w_cpu_win;
    logic              w_dma_win;
    logic              w_accept;
    logic              w_contend;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_sel_oor;

    assign w_contend = io_cpu.valid & io_dma.valid;

`ifdef DMEM_ARB_RR_EN
    // Set when DMA took the most recent contended cycle, so CPU gets the next one.
    logic r_last_dma;

    assign w_dma_win = io_dma.valid & (~io_cpu.valid | ~r_last_dma);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_dma <= 1'b0;
        end else if (w_contend) begin
            r_last_dma <= w_dma_win;
        end
    end
`else
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] r_wait_cnt;

    assign w_dma_win = io_dma.valid & (~io_cpu.valid | (r_wait_cnt == CNT_W'(MAX_WAIT)));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wait_cnt <= '0;
        end else if (w_contend & ~w_dma_win) begin
            if (r_wait_cnt != CNT_W'(MAX_WAIT)) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end else begin
            r_wait_cnt <= '0;
        end
    end
`endif

    assign w_cpu_win   = io_cpu.valid & ~w_dma_win;
    assign w_accept    = w_cpu_win | w_dma_win;
    assign w_sel_we    = w_dma_win ? io_dma.we    : io_cpu.we;
    assign w_sel_addr  = w_dma_win ? io_dma.addr  : io_cpu.addr;
    assign w_sel_wdata = w_dma_win ? io_dma.wdata : io_cpu.wdata;
    assign w_sel_oor   = w_sel_addr > LAST_OK;

    assign io_cpu.ready = w_cpu_win;
    assign io_dma.ready = w_dma_win;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_mem_we     <= 1'b0;
            r_mem_re     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_s1_dma     <= 1'b0;
            r_s1_oor     <= 1'b0;
            r_cpu_rvalid <= 1'b0;
            r_cpu_rdata  <= '0;
            r_cpu_err    <= 1'b0;
            r_dma_rvalid <= 1'b0;
            r_dma_rdata  <= '0;
            r_dma_err    <= 1'b0;
        end else begin
            r_state  <= w_accept ? S_ACCESS : S_IDLE;
            // Out-of-range slots still occupy the pipeline but never touch memory.
            r_mem_we <= w_accept & w_sel_we & ~w_sel_oor;
            r_mem_re <= w_accept & ~w_sel_we & ~w_sel_oor;
            if (w_accept) begin
                r_mem_addr  <= w_sel_addr;
                r_mem_wdata <= w_sel_wdata;
                r_s1_dma    <= w_dma_win;
                r_s1_oor    <= w_sel_oor;
            end

            r_cpu_rvalid <= (r_state == S_ACCESS) & ~r_s1_dma;
            r_cpu_rdata  <= ((r_state == S_ACCESS) & ~r_s1_dma & r_mem_re) ? i_mem_data_out : '0;
            r_cpu_err    <= (r_state == S_ACCESS) & ~r_s1_dma & r_s1_oor;
            r_dma_rvalid <= (r_state == S_ACCESS) & r_s1_dma;
            r_dma_rdata  <= ((r_state == S_ACCESS) & r_s1_dma & r_mem_re) ? i_mem_data_out : '0;
            r_dma_err    <= (r_state == S_ACCESS) & r_s1_dma & r_s1_oor;
        end
    end

    assign o_mem_write_enable = r_mem_we;
    assign o_mem_read_enable  = r_mem_re;
    assign o_mem_address      = r_mem_addr;
    assign o_mem_data_in      = r_mem_wdata;

    assign io_cpu.rvalid = r_cpu_rvalid;
    assign io_cpu.rdata  = r_cpu_rdata;
    assign io_cpu.err    = r_cpu_err;
    assign io_dma.rvalid = r_dma_rvalid;
    assign io_dma.rdata  = r_dma_rdata;
    assign io_dma.err    = r_dma_err;
endmodule
